// File: rtl/hwpe_stream_zero_sink_pkg.sv
// Shared types for the zero-stream sink and its stability checker.
// State encoding of the optional HWPE_STREAM_ZERO_SINK_STABILITY_CHECK_EN FSM.
package hwpe_stream_package;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hwpe_stream_zero_sink_state_e;

endpackage

// File: rtl/hwpe_stream_zero_sink_if.sv
// Valid/ready/strb stream bundle used by both the normal and the zero (shadow) stream.
// The monitor modport only observes; sink drives ready back to the producer.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source  (output valid, data, strb, input ready);
    modport sink    (input valid, data, strb, output ready);
    modport monitor (input valid, data, strb, ready);

endinterface

// File: rtl/hwpe_stream_zero_sink_stability_checker.sv
// Handshake-stability check on the zero stream: valid and strb must hold until ready.
// Only built when HWPE_STREAM_ZERO_SINK_STABILITY_CHECK_EN is defined.
`ifdef HWPE_STREAM_ZERO_SINK_STABILITY_CHECK_EN
module hwpe_stream_zero_stability_checker
    import hwpe_stream_package::*;
#(
    parameter int unsigned STRB_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid,
    input  logic                  ready,
    input  logic [STRB_WIDTH-1:0] strb,
    output logic                  stab_fault
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_HOLD = HOLD;

    logic [0:0]            state_q, state_d;
    logic [STRB_WIDTH-1:0] capt_q, capt_d;

    always_comb begin
        state_d    = state_q;
        capt_d     = capt_q;
        stab_fault = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid && !ready) begin
                    state_d = S_HOLD;
                    capt_d  = strb;
                end
            end
            S_HOLD: begin
                if (!valid) begin
                    stab_fault = 1'b1;
                    state_d    = S_IDLE;
                end else if (strb != capt_q) begin
                    // Keep tracking the new value so one glitch is reported once.
                    stab_fault = 1'b1;
                    capt_d     = strb;
                end else if (ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage boundary: FSM state and strb capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            capt_q  <= '0;
        end else begin
            state_q <= state_d;
            capt_q  <= capt_d;
        end
    end

endmodule
`endif

// File: rtl/hwpe_stream_zero_sink.sv
// Consumer end of the zero (shadow) stream: mirrors ready and flags valid/strb divergence.
// Define HWPE_STREAM_ZERO_SINK_STABILITY_CHECK_EN to add the zero-stream stability FSM.
module hwpe_stream_zero_sink
    import hwpe_stream_package::*;
#(
    parameter int unsigned STRB_WIDTH      = 4,
    parameter int unsigned FAULT_CNT_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    hwpe_stream_intf_stream.monitor    normal_i,
    hwpe_stream_intf_stream.sink       zero_i,
    output logic                       fault_detected_o,
    output logic                       fault_sticky_o,
    output logic [FAULT_CNT_WIDTH-1:0] fault_count_o
);

    function automatic logic [FAULT_CNT_WIDTH-1:0] sat_inc(input logic [FAULT_CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + FAULT_CNT_WIDTH'(1);
    endfunction

    logic [STRB_WIDTH-1:0] normal_strb;
    logic [STRB_WIDTH-1:0] zero_strb;
    logic                  mismatch;
    logic                  stab_fault;
    logic                  fault_p0;
    logic                  unused_data;

    assign zero_i.ready = normal_i.ready;
    assign normal_strb  = normal_i.strb;
    assign zero_strb    = zero_i.strb;
    assign unused_data  = ^{normal_i.data, zero_i.data};

    // strb only carries meaning while both sides present a beat.
    assign mismatch = (normal_i.valid != zero_i.valid) |
                      (normal_i.valid & zero_i.valid & (normal_strb != zero_strb));

`ifdef HWPE_STREAM_ZERO_SINK_STABILITY_CHECK_EN
    hwpe_stream_zero_stability_checker #(
        .STRB_WIDTH (STRB_WIDTH)
    ) i_stability (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid      (zero_i.valid),
        .ready      (zero_i.ready),
        .strb       (zero_strb),
        .stab_fault (stab_fault)
    );
`else
    assign stab_fault = 1'b0;
`endif

    assign fault_p0 = mismatch | stab_fault;

    // Stage boundary: fault pulse, sticky flag and saturating counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_detected_o <= 1'b0;
            fault_sticky_o   <= 1'b0;
            fault_count_o    <= '0;
        end else begin
            fault_detected_o <= fault_p0;
            fault_sticky_o   <= fault_p0 | (fault_sticky_o & ~clear_i);
            if (clear_i)
                fault_count_o <= fault_p0 ? FAULT_CNT_WIDTH'(1) : '0;
            else if (fault_p0)
                fault_count_o <= sat_inc(fault_count_o);
        end
    end

endmodule

// File: tb/tb_hwpe_stream_zero_sink.sv
// Directed bench for hwpe_stream_zero_sink with a 2-bit fault counter.
module tb_hwpe_stream_zero_sink;

`ifdef HWPE_STREAM_ZERO_SINK_STABILITY_CHECK_EN
    localparam logic STAB = 1'b1;
`else
    localparam logic STAB = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       det;
    logic       sticky;
    logic [1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) normal ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) zero ();

    hwpe_stream_zero_sink #(
        .STRB_WIDTH      (4),
        .FAULT_CNT_WIDTH (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_i          (clear),
        .normal_i         (normal),
        .zero_i           (zero),
        .fault_detected_o (det),
        .fault_sticky_o   (sticky),
        .fault_count_o    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       nv;
        logic       zv;
        logic [3:0] ns;
        logic [3:0] zs;
        logic       rdy;
        logic       clr;
        logic       e_det;
        logic       e_sticky;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check ready mirroring, advance to just after the edge.
    task automatic step(input logic nv, input logic zv, input logic [3:0] ns, input logic [3:0] zs,
                        input logic rdy, input logic clr);
        normal.valid = nv;
        zero.valid   = zv;
        normal.strb  = ns;
        zero.strb    = zs;
        normal.ready = rdy;
        clear        = clr;
        normal.data  = $urandom;
        zero.data    = $urandom;
        #1;
        check("zero_ready", {31'd0, zero.ready}, {31'd0, rdy});
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string nm, input logic e_det, input logic e_sticky, input logic [1:0] e_cnt);
        check({nm, "_det"},    {31'd0, det},    {31'd0, e_det});
        check({nm, "_sticky"}, {31'd0, sticky}, {31'd0, e_sticky});
        check({nm, "_cnt"},    {30'd0, cnt},    {30'd0, e_cnt});
    endtask

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        normal.valid = 1'b0;
        normal.ready = 1'b0;
        normal.strb  = 4'h0;
        normal.data  = '0;
        zero.valid   = 1'b0;
        zero.strb    = 4'h0;
        zero.data    = '0;

        // nv zv ns zs rdy clr | det sticky cnt  (ready held high keeps the FSM idle)
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
        vecs[1]  = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 1'b1, 4'hF, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 1'b0, 4'hF, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
        vecs[5]  = '{1'b1, 1'b0, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
        vecs[6]  = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
        vecs[7]  = '{1'b1, 1'b1, 4'hC, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 4'hC, 4'hC, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 1'b1, 4'hC, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 4'hC, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};

        #2;
        outs("reset", 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Matched traffic with toggling ready: never a fault.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 4'hF, 4'hF, logic'(i % 2), 1'b0);
            outs($sformatf("matched%0d", i), 1'b0, 1'b0, 2'd0);
        end

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].nv, vecs[i].zv, vecs[i].ns, vecs[i].zs, vecs[i].rdy, vecs[i].clr);
            outs($sformatf("vec%0d", i), vecs[i].e_det, vecs[i].e_sticky, vecs[i].e_cnt);
        end

        // Fault pulse lasts one cycle only.
        step(1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0);
        outs("pulse_a", 1'b1, 1'b1, 2'd1);
        step(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0);
        outs("pulse_b", 1'b0, 1'b1, 2'd1);
        step(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
        outs("pulse_clr", 1'b0, 1'b0, 2'd0);

        // Stability: strb changes while stalled, then valid withdrawn; both streams identical.
        step(1'b1, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0);
        outs("stab_hold", 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0);
        outs("stab_strb", STAB, STAB, {1'b0, STAB});
        step(1'b1, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0);
        outs("stab_recap", 1'b0, STAB, {1'b0, STAB});
        step(1'b0, 1'b0, 4'h5, 4'h5, 1'b0, 1'b0);
        outs("stab_drop", STAB, STAB, {STAB, 1'b0});
        step(1'b0, 1'b0, 4'h5, 4'h5, 1'b0, 1'b0);
        outs("stab_idle", 1'b0, STAB, {STAB, 1'b0});
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        outs("stab_clr", 1'b0, 1'b0, 2'd0);

        // Build sticky=1, count=2, leave the zero stream stalled, then reset asynchronously.
        step(1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0);
        outs("pre_rst1", 1'b1, 1'b1, 2'd1);
        step(1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0);
        outs("pre_rst2", 1'b1, 1'b1, 2'd2);
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        outs("pre_rst3", 1'b0, 1'b1, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        outs("async_rst", 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        outs("in_rst", 1'b0, 1'b0, 2'd0);
        // A different strb right after release exposes any state left over from before reset.
        normal.strb = 4'h3;
        zero.strb   = 4'h3;
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
        outs("post_rst1", 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 4'h3, 4'h3, 1'b1, 1'b0);
        outs("post_rst2", 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 4'h3, 4'h3, 1'b1, 1'b0);
        outs("post_rst3", 1'b0, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
